// File: rtl/timer_run_ctrl.sv
// timer_run_ctrl: run-time controller for the countdown timer.
// Loads the clamped preset while idle, counts down on the 1 Hz tick,
// handles start/pause/clear/acknowledge pulses and raises a timed alarm
// when the count reaches 0:00:00. All outputs come straight from registers.
module timer_run_ctrl #(
  parameter logic [3:0]  MODE_TIMER = 4'b0001,
  parameter int unsigned ALARM_SECS = 10
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] MODE,
  input  logic [3:0] BTN_SYNC,
  input  logic       TICK_1HZ,
  input  logic [6:0] SET_HOUR,
  input  logic [6:0] SET_MIN,
  input  logic [6:0] SET_SEC,
  output logic [6:0] HOUR,
  output logic [6:0] MIN,
  output logic [6:0] SEC,
  output logic [1:0] STATE,
  output logic       ALARM
);

  typedef enum logic [1:0] {
    IDLE_ST  = 2'b00,
    RUN_ST   = 2'b01,
    PAUSE_ST = 2'b10,
    DONE_ST  = 2'b11
  } state_t;

  localparam logic [7:0] ALARM_LOAD = 8'(ALARM_SECS);
  localparam logic [6:0] HOUR_MAX   = 7'd12;
  localparam logic [6:0] MINSEC_MAX = 7'd59;

  // Saturate a preset field to its legal maximum.
  function automatic logic [6:0] clamp_f(input logic [6:0] val, input logic [6:0] lim);
    logic [6:0] res;
    if (val > lim) begin
      res = lim;
    end else begin
      res = val;
    end
    return res;
  endfunction

  state_t     state_r, state_nxt_s;
  logic [6:0] hour_r, min_r, sec_r;
  logic [6:0] hour_nxt_s, min_nxt_s, sec_nxt_s;
  logic       alarm_r, alarm_nxt_s;
  logic [7:0] acnt_r, acnt_nxt_s;

  logic       btn_ok_s;
  logic       clr_s, ack_s, pause_s, start_s;
  logic [6:0] pre_hour_s, pre_min_s, pre_sec_s;
  logic       pre_nz_s;
  logic [6:0] dec_hour_s, dec_min_s, dec_sec_s;
  logic       dec_zero_s;

  // Qualify buttons by mode and keep only the highest-priority pulse.
  always_comb begin
    btn_ok_s = (MODE == MODE_TIMER);
    clr_s    = btn_ok_s & BTN_SYNC[2];
    ack_s    = btn_ok_s & BTN_SYNC[3] & ~BTN_SYNC[2];
    pause_s  = btn_ok_s & BTN_SYNC[1] & ~BTN_SYNC[2] & ~BTN_SYNC[3];
    start_s  = btn_ok_s & BTN_SYNC[0] & ~BTN_SYNC[1] & ~BTN_SYNC[2] & ~BTN_SYNC[3];
  end

  // Clamp the incoming preset and flag whether it is nonzero.
  always_comb begin
    pre_hour_s = clamp_f(SET_HOUR, HOUR_MAX);
    pre_min_s  = clamp_f(SET_MIN, MINSEC_MAX);
    pre_sec_s  = clamp_f(SET_SEC, MINSEC_MAX);
    pre_nz_s   = (pre_hour_s != 7'd0) || (pre_min_s != 7'd0) || (pre_sec_s != 7'd0);
  end

  // One-second borrow-chain decrement of the current count.
  always_comb begin
    dec_hour_s = hour_r;
    dec_min_s  = min_r;
    dec_sec_s  = sec_r;
    if (sec_r != 7'd0) begin
      dec_sec_s = sec_r - 7'd1;
    end else if (min_r != 7'd0) begin
      dec_min_s = min_r - 7'd1;
      dec_sec_s = MINSEC_MAX;
    end else if (hour_r != 7'd0) begin
      dec_hour_s = hour_r - 7'd1;
      dec_min_s  = MINSEC_MAX;
      dec_sec_s  = MINSEC_MAX;
    end else begin
      dec_sec_s = 7'd0;
    end
    dec_zero_s = (dec_hour_s == 7'd0) && (dec_min_s == 7'd0) && (dec_sec_s == 7'd0);
  end

  // Next-state, count, alarm and alarm-counter logic.
  always_comb begin
    state_nxt_s = state_r;
    hour_nxt_s  = hour_r;
    min_nxt_s   = min_r;
    sec_nxt_s   = sec_r;
    alarm_nxt_s = alarm_r;
    acnt_nxt_s  = acnt_r;
    case (state_r)
      IDLE_ST: begin
        hour_nxt_s  = pre_hour_s;
        min_nxt_s   = pre_min_s;
        sec_nxt_s   = pre_sec_s;
        alarm_nxt_s = 1'b0;
        acnt_nxt_s  = 8'd0;
        if (start_s && pre_nz_s) begin
          state_nxt_s = RUN_ST;
        end else begin
          state_nxt_s = IDLE_ST;
        end
      end
      RUN_ST: begin
        if (clr_s) begin
          state_nxt_s = IDLE_ST;
        end else if (pause_s) begin
          state_nxt_s = PAUSE_ST;
        end else if (TICK_1HZ) begin
          hour_nxt_s = dec_hour_s;
          min_nxt_s  = dec_min_s;
          sec_nxt_s  = dec_sec_s;
          if (dec_zero_s) begin
            state_nxt_s = DONE_ST;
            alarm_nxt_s = 1'b1;
            acnt_nxt_s  = ALARM_LOAD;
          end else begin
            state_nxt_s = RUN_ST;
          end
        end else begin
          state_nxt_s = RUN_ST;
        end
      end
      PAUSE_ST: begin
        if (clr_s) begin
          state_nxt_s = IDLE_ST;
        end else if (start_s) begin
          state_nxt_s = RUN_ST;
        end else begin
          state_nxt_s = PAUSE_ST;
        end
      end
      DONE_ST: begin
        hour_nxt_s = 7'd0;
        min_nxt_s  = 7'd0;
        sec_nxt_s  = 7'd0;
        if (clr_s || ack_s) begin
          state_nxt_s = IDLE_ST;
          alarm_nxt_s = 1'b0;
          acnt_nxt_s  = 8'd0;
        end else if (TICK_1HZ) begin
          // A counter already at 0 would never expire, so treat it as last tick too.
          if (acnt_r <= 8'd1) begin
            state_nxt_s = IDLE_ST;
            alarm_nxt_s = 1'b0;
            acnt_nxt_s  = 8'd0;
          end else begin
            acnt_nxt_s = acnt_r - 8'd1;
          end
        end else begin
          state_nxt_s = DONE_ST;
        end
      end
      default: begin
        state_nxt_s = IDLE_ST;
        hour_nxt_s  = 7'd0;
        min_nxt_s   = 7'd0;
        sec_nxt_s   = 7'd0;
        alarm_nxt_s = 1'b0;
        acnt_nxt_s  = 8'd0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r <= IDLE_ST;
      hour_r  <= 7'd0;
      min_r   <= 7'd0;
      sec_r   <= 7'd0;
      alarm_r <= 1'b0;
      acnt_r  <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      hour_r  <= hour_nxt_s;
      min_r   <= min_nxt_s;
      sec_r   <= sec_nxt_s;
      alarm_r <= alarm_nxt_s;
      acnt_r  <= acnt_nxt_s;
    end
  end

  assign HOUR  = hour_r;
  assign MIN   = min_r;
  assign SEC   = sec_r;
  assign STATE = state_r;
  assign ALARM = alarm_r;

endmodule

// File: tb/tb_timer_run_ctrl.sv
// tb_timer_run_ctrl: directed-vector bench for timer_run_ctrl.
module tb_timer_run_ctrl;

  logic       CLK;
  logic       RESET;
  logic [3:0] MODE;
  logic [3:0] BTN_SYNC;
  logic       TICK_1HZ;
  logic [6:0] SET_HOUR, SET_MIN, SET_SEC;
  logic [6:0] HOUR, MIN, SEC;
  logic [1:0] STATE;
  logic       ALARM;

  int vec_cnt;
  int err_cnt;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;

  localparam logic [3:0] B_START = 4'b0001;
  localparam logic [3:0] B_PAUSE = 4'b0010;
  localparam logic [3:0] B_CLR   = 4'b0100;
  localparam logic [3:0] B_ACK   = 4'b1000;

  timer_run_ctrl #(.MODE_TIMER(4'b0001), .ALARM_SECS(10)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .MODE     (MODE),
    .BTN_SYNC (BTN_SYNC),
    .TICK_1HZ (TICK_1HZ),
    .SET_HOUR (SET_HOUR),
    .SET_MIN  (SET_MIN),
    .SET_SEC  (SET_SEC),
    .HOUR     (HOUR),
    .MIN      (MIN),
    .SEC      (SEC),
    .STATE    (STATE),
    .ALARM    (ALARM)
  );

  // Free-running 100 MHz clock.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse(input logic [3:0] btn, input logic tk);
    BTN_SYNC = btn;
    TICK_1HZ = tk;
    step();
    BTN_SYNC = 4'b0000;
    TICK_1HZ = 1'b0;
  endtask

  task automatic set_preset(input logic [6:0] h, input logic [6:0] m, input logic [6:0] s);
    SET_HOUR = h;
    SET_MIN  = m;
    SET_SEC  = s;
    step();
  endtask

  task automatic check_count(input string tag, input logic [6:0] h, input logic [6:0] m, input logic [6:0] s);
    check_vec({tag, ".hour"}, 32'(HOUR), 32'(h));
    check_vec({tag, ".min"},  32'(MIN),  32'(m));
    check_vec({tag, ".sec"},  32'(SEC),  32'(s));
  endtask

  initial begin
    vec_cnt  = 0;
    err_cnt  = 0;
    RESET    = 1'b0;
    MODE     = 4'b0001;
    BTN_SYNC = 4'b0000;
    TICK_1HZ = 1'b0;
    SET_HOUR = 7'd0;
    SET_MIN  = 7'd0;
    SET_SEC  = 7'd3;
    step();
    step();
    check_vec("rst.state", 32'(STATE), 32'(S_IDLE));
    check_vec("rst.alarm", 32'(ALARM), 32'd0);
    check_count("rst", 7'd0, 7'd0, 7'd0);
    RESET = 1'b1;
    step();
    check_count("idle_load", 7'd0, 7'd0, 7'd3);

    // Basic countdown 0:00:03
    pulse(B_START, 1'b0);
    check_vec("start.state", 32'(STATE), 32'(S_RUN));
    check_vec("start.sec", 32'(SEC), 32'd3);
    pulse(4'b0000, 1'b1);
    check_vec("cd1.sec", 32'(SEC), 32'd2);
    pulse(4'b0000, 1'b1);
    check_vec("cd2.sec", 32'(SEC), 32'd1);
    pulse(4'b0000, 1'b1);
    check_vec("cd3.sec", 32'(SEC), 32'd0);
    check_vec("cd3.state", 32'(STATE), 32'(S_DONE));
    check_vec("cd3.alarm", 32'(ALARM), 32'd1);

    // Alarm timeout after ten ticks
    for (int i = 1; i <= 9; i++) begin
      pulse(4'b0000, 1'b1);
      check_vec($sformatf("alm%0d.alarm", i), 32'(ALARM), 32'd1);
      check_vec($sformatf("alm%0d.state", i), 32'(STATE), 32'(S_DONE));
    end
    pulse(4'b0000, 1'b1);
    check_vec("alm10.alarm", 32'(ALARM), 32'd0);
    check_vec("alm10.state", 32'(STATE), 32'(S_IDLE));
    step();
    check_vec("reload.sec", 32'(SEC), 32'd3);

    // Borrow chain 1:00:00 -> 0:59:59
    set_preset(7'd1, 7'd0, 7'd0);
    pulse(B_START, 1'b0);
    pulse(4'b0000, 1'b1);
    check_count("borrow", 7'd0, 7'd59, 7'd59);

    // Clear back to idle, then preset reloads
    pulse(B_CLR, 1'b0);
    check_vec("clr.state", 32'(STATE), 32'(S_IDLE));
    step();
    check_count("clr_reload", 7'd1, 7'd0, 7'd0);

    // Pause/resume from 0:01:00
    set_preset(7'd0, 7'd1, 7'd0);
    pulse(B_START, 1'b0);
    pulse(4'b0000, 1'b1);
    check_count("pr_run", 7'd0, 7'd0, 7'd59);
    pulse(B_PAUSE, 1'b0);
    check_vec("pause.state", 32'(STATE), 32'(S_PAUSE));
    for (int i = 0; i < 5; i++) begin
      pulse(4'b0000, 1'b1);
    end
    check_count("pause_hold", 7'd0, 7'd0, 7'd59);
    pulse(B_START, 1'b1);
    check_vec("resume.state", 32'(STATE), 32'(S_RUN));
    check_vec("resume.sec", 32'(SEC), 32'd59);
    pulse(4'b0000, 1'b1);
    check_vec("resume_tick.sec", 32'(SEC), 32'd58);

    // Start+clear with a tick during RUN: clear wins, no decrement
    pulse(B_START | B_CLR, 1'b1);
    check_vec("stclr.state", 32'(STATE), 32'(S_IDLE));
    check_vec("stclr.sec", 32'(SEC), 32'd58);

    // Acknowledge in DONE, ignored outside timer mode
    set_preset(7'd0, 7'd0, 7'd1);
    pulse(B_START, 1'b0);
    pulse(4'b0000, 1'b1);
    check_vec("ack_pre.state", 32'(STATE), 32'(S_DONE));
    MODE = 4'b0000;
    pulse(B_ACK, 1'b0);
    check_vec("ack_mode0.state", 32'(STATE), 32'(S_DONE));
    check_vec("ack_mode0.alarm", 32'(ALARM), 32'd1);
    MODE = 4'b0001;
    pulse(B_ACK, 1'b0);
    check_vec("ack.state", 32'(STATE), 32'(S_IDLE));
    check_vec("ack.alarm", 32'(ALARM), 32'd0);

    // Zero preset: start ignored
    set_preset(7'd0, 7'd0, 7'd0);
    pulse(B_START, 1'b0);
    check_vec("zero.state", 32'(STATE), 32'(S_IDLE));

    // Clamping of out-of-range presets
    set_preset(7'd20, 7'd80, 7'd75);
    step();
    check_count("clamp", 7'd12, 7'd59, 7'd59);

    // Start with a tick from IDLE: tick not consumed
    set_preset(7'd0, 7'd0, 7'd5);
    pulse(B_START, 1'b1);
    check_vec("st_tick.state", 32'(STATE), 32'(S_RUN));
    check_vec("st_tick.sec", 32'(SEC), 32'd5);
    pulse(4'b0000, 1'b1);
    check_vec("st_tick2.sec", 32'(SEC), 32'd4);

    // Pause ignored outside timer mode, counting continues
    MODE = 4'b0010;
    pulse(B_PAUSE, 1'b1);
    check_vec("mode_pause.state", 32'(STATE), 32'(S_RUN));
    check_vec("mode_pause.sec", 32'(SEC), 32'd3);
    MODE = 4'b0001;

    // Preset change while running has no effect
    SET_SEC = 7'd40;
    pulse(4'b0000, 1'b1);
    check_vec("preset_run.sec", 32'(SEC), 32'd2);

    // Asynchronous reset mid-RUN, checked before any clock edge
    RESET = 1'b0;
    #2;
    check_vec("arst.state", 32'(STATE), 32'(S_IDLE));
    check_vec("arst.alarm", 32'(ALARM), 32'd0);
    check_count("arst", 7'd0, 7'd0, 7'd0);
    RESET = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/timer_run_ctrl.md
# timer_run_ctrl

Run-time controller for the countdown timer. It loads the preset HOUR/MIN/SEC produced by the timer-set logic, sequences the countdown on a 1 Hz tick, and handles start/pause/clear button pulses. It raises a timed alarm when the count reaches 0:00:00. It sits between the timer-set block and the display mux, and its count outputs drive the display whenever the timer mode is selected.

## Interface
Parameters:
- MODE_TIMER, 4'b0001, MODE value in which button pulses are accepted
- ALARM_SECS, 10, number of ticks ALARM stays high after expiry (1..255)

Ports:
- CLK  input  1  system clock; all state changes on posedge
- RESET  input  1  asynchronous, active-low reset
- MODE  input  4  current top-level mode
- BTN_SYNC  input  4  single-cycle synchronized button pulses: [0] start/resume, [1] pause, [2] clear, [3] alarm acknowledge
- TICK_1HZ  input  1  single-cycle pulse, once per second
- SET_HOUR  input  7  preset hours, binary, 0..12
- SET_MIN  input  7  preset minutes, binary, 0..59
- SET_SEC  input  7  preset seconds, binary, 0..59
- HOUR  output  7  current count, hours
- MIN  output  7  current count, minutes
- SEC  output  7  current count, seconds
- STATE  output  2  00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
- ALARM  output  1  high while in DONE

## Operation
- Reset (RESET=0, async) sets STATE=IDLE, HOUR=MIN=SEC=0, ALARM=0, and alarm counter=0.
- Buttons are acted on only when MODE==MODE_TIMER. In other modes, buttons are ignored but counting and the alarm continue.
- Button priority within one cycle: clear > acknowledge > pause > start. Only the highest-priority pulse acts.
- IDLE:
  - Each cycle, load HOUR/MIN/SEC from SET_*, clamped: HOUR to at most 12, MIN and SEC to at most 59.
  - Start with a nonzero clamped preset -> RUN.
  - Start with a zero preset is ignored.
- RUN:
  - On TICK_1HZ, decrement as a borrow chain:
    - SEC>0: SEC-1.
    - Otherwise, MIN>0: MIN-1 and SEC=59.
    - Otherwise, HOUR>0: HOUR-1 and MIN=SEC=59.
  - If the post-decrement value is 0:00:00, go to DONE on the same edge, set ALARM=1, and load the alarm counter with ALARM_SECS.
  - Pause -> PAUSE. Clear -> IDLE.
- PAUSE:
  - Count is held and ticks are ignored.
  - Start -> RUN. Clear -> IDLE.
- DONE:
  - Count stays at 0:00:00.
  - Each tick decrements the alarm counter. When the counter goes 1->0, ALARM goes to 0 and STATE goes to IDLE on that edge.
  - Acknowledge or clear -> IDLE immediately, with ALARM=0.
  - Start and pause are ignored.
- Entering IDLE from any state reloads the preset on the next cycle.
- Arithmetic: all count fields are unsigned 7-bit. No field ever leaves 0..59 (HOUR 0..12). The alarm counter is 8-bit.

## Timing
- All outputs are registered, with 1-cycle latency from the qualifying input edge to the output change.
- A tick and a button in the same cycle:
  - Clear/pause win over the tick: no decrement occurs.
  - Start from PAUSE and a tick in the same cycle: the state goes to RUN and the tick is not consumed.
- A tick in the same cycle as start from IDLE is not consumed. The first decrement occurs on the next tick.
- Reset asserted mid-RUN or mid-DONE: outputs go to reset values immediately (asynchronous), without waiting for a clock edge.
- A preset change while in RUN/PAUSE/DONE has no effect on the count.

## Test plan
- Basic countdown: preset 0:00:03, start, 3 ticks -> SEC goes 2,1,0; STATE=DONE and ALARM=1 on the third tick edge.
- Borrow chain: preset 1:00:00, start, 1 tick -> 0:59:59.
- Pause/resume: 0:01:00 running, tick to 0:00:59, pause, 5 ticks -> count stays 0:00:59; start, 1 tick -> 0:00:58.
- Alarm timeout: ALARM_SECS=10, reach DONE, 10 ticks -> ALARM=1 through the 9th tick, ALARM=0 and STATE=IDLE on the 10th.
- Acknowledge in DONE:
  - BTN_SYNC=4'b1000 with MODE=MODE_TIMER -> IDLE next cycle.
  - Same pulse with MODE=0000 -> ignored, still DONE.
- Priority and edge cases:
  - Start and clear in the same cycle during RUN -> IDLE.
  - Start with preset 0:00:00 -> stays IDLE.
  - SET_SEC=75 -> SEC=59.
  - RESET low mid-RUN -> 0:00:00, IDLE, ALARM=0 without a clock edge.
